// File: rtl/game_tick_sequencer.sv
// Game frame tick generator and per-frame update sequencer: divides clk into frame
// ticks, then strobes the paddle update, then the ball update, with serve pauses.
module game_tick_sequencer #(
    parameter int DIV_W       = 18,
    parameter int TICK_DIV    = 262143,
    parameter int SERVE_TICKS = 60
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic serve_req,
    input  logic paddle_done,
    input  logic ball_done,
    input  logic clr_overrun,
    output logic frame_tick,
    output logic paddle_go,
    output logic ball_go,
    output logic ball_reset,
    output logic busy,
    output logic serving,
    output logic overrun
);

    localparam int CNT_W = $clog2(SERVE_TICKS + 1);
    localparam logic [DIV_W-1:0] DIV_TC     = DIV_W'(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
    localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // state  | meaning
    // IDLE   | waiting for a frame tick or a serve request
    // PADDLE | paddle update in progress, waiting for paddle_done
    // BALL   | ball update in progress, waiting for ball_done
    // SERVE  | frozen frames after a point, counting ticks down
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PADDLE = 2'd1,
        S_BALL   = 2'd2,
        S_SERVE  = 2'd3
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_serve_cnt;
    logic             r_pending;
    logic             r_paddle_go;
    logic             r_ball_go;
    logic             r_ball_reset;
    logic             r_overrun;

    logic w_div_tc;
    logic w_tick;
    logic w_busy;

    assign w_div_tc = (r_div == DIV_TC);
    assign w_tick   = run & w_div_tc;
    assign w_busy   = (r_state == S_PADDLE) || (r_state == S_BALL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (run) begin
            r_div <= w_div_tc ? '0 : r_div + DIV_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_pending    <= 1'b0;
            r_serve_cnt  <= '0;
            r_paddle_go  <= 1'b0;
            r_ball_go    <= 1'b0;
            r_ball_reset <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_paddle_go  <= 1'b0;
            r_ball_go    <= 1'b0;
            r_ball_reset <= 1'b0;

            // A tick landing mid-update is dropped, only flagged; set beats clear.
            if (w_tick && w_busy) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun) begin
                r_overrun <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (serve_req || r_pending) begin
                        r_state      <= S_SERVE;
                        r_serve_cnt  <= SERVE_LOAD;
                        r_pending    <= 1'b0;
                        r_ball_reset <= 1'b1;
                    end else if (w_tick) begin
                        r_state     <= S_PADDLE;
                        r_paddle_go <= 1'b1;
                    end
                end
                S_PADDLE: begin
                    if (serve_req) begin
                        r_pending <= 1'b1;
                    end
                    if (paddle_done) begin
                        r_state   <= S_BALL;
                        r_ball_go <= 1'b1;
                    end
                end
                S_BALL: begin
                    if (serve_req) begin
                        r_pending <= 1'b1;
                    end
                    if (ball_done) begin
                        r_state <= S_IDLE;
                    end
                end
                S_SERVE: begin
                    // The tick that ends the pause is consumed, not forwarded.
                    if (w_tick) begin
                        if (r_serve_cnt == CNT_ONE) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_serve_cnt <= r_serve_cnt - CNT_ONE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign frame_tick = w_tick;
    assign paddle_go  = r_paddle_go;
    assign ball_go    = r_ball_go;
    assign ball_reset = r_ball_reset;
    assign busy       = w_busy;
    assign serving    = (r_state == S_SERVE);
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_game_tick_sequencer.sv
// Bench for game_tick_sequencer: directed scenarios then random traffic, every cycle
// compared against a frame-level reference model kept in the bench.
module tb_game_tick_sequencer;

    localparam int TD = 3;
    localparam int ST = 2;
    localparam int PH_IDLE   = 0;
    localparam int PH_PADDLE = 1;
    localparam int PH_BALL   = 2;
    localparam int PH_SERVE  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0;
    logic serve_req = 1'b0;
    logic paddle_done = 1'b0;
    logic ball_done = 1'b0;
    logic clr_overrun = 1'b0;
    logic frame_tick, paddle_go, ball_go, ball_reset, busy, serving, overrun;

    game_tick_sequencer #(
        .DIV_W(18),
        .TICK_DIV(TD),
        .SERVE_TICKS(ST)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .run(run),
        .serve_req(serve_req),
        .paddle_done(paddle_done),
        .ball_done(ball_done),
        .clr_overrun(clr_overrun),
        .frame_tick(frame_tick),
        .paddle_go(paddle_go),
        .ball_go(ball_go),
        .ball_reset(ball_reset),
        .busy(busy),
        .serving(serving),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // reference model: clocks elapsed in the frame, current phase, frozen frames left
    int m_div;
    int m_phase;
    int m_frames_left;
    bit m_pending, m_pgo, m_bgo, m_brst, m_ovr;

    // done responder
    int p_delay = 0, b_delay = 0, p_cnt = -1, b_cnt = -1;
    bit rand_delays = 0, spur_p = 0, spur_b = 0;
    int tick_seen = 0, pgo_seen = 0, bgo_seen = 0;

    function automatic bit m_tick_now();
        return (run == 1'b1) && (m_div == TD);
    endfunction

    function automatic bit m_busy();
        return (m_phase == PH_PADDLE) || (m_phase == PH_BALL);
    endfunction

    function automatic logic [6:0] exp_vec();
        return {m_tick_now(), m_pgo, m_bgo, m_brst, m_busy(), (m_phase == PH_SERVE), m_ovr};
    endfunction

    function automatic logic [6:0] obs_vec();
        return {frame_tick, paddle_go, ball_go, ball_reset, busy, serving, overrun};
    endfunction

    task automatic model_reset();
        m_div = 0; m_phase = PH_IDLE; m_frames_left = 0;
        m_pending = 0; m_pgo = 0; m_bgo = 0; m_brst = 0; m_ovr = 0;
        p_cnt = -1; b_cnt = -1;
    endtask

    task automatic model_step();
        bit t;
        bit bz;
        t  = m_tick_now();
        bz = m_busy();
        if (run == 1'b1) m_div = t ? 0 : m_div + 1;
        m_pgo = 0; m_bgo = 0; m_brst = 0;
        if (t && bz) m_ovr = 1;
        else if (clr_overrun == 1'b1) m_ovr = 0;
        if (m_phase == PH_IDLE) begin
            if (serve_req == 1'b1 || m_pending) begin
                m_phase = PH_SERVE; m_frames_left = ST; m_pending = 0; m_brst = 1;
            end else if (t) begin
                m_phase = PH_PADDLE; m_pgo = 1;
            end
        end else if (m_phase == PH_PADDLE) begin
            if (serve_req == 1'b1) m_pending = 1;
            if (paddle_done == 1'b1) begin m_phase = PH_BALL; m_bgo = 1; end
        end else if (m_phase == PH_BALL) begin
            if (serve_req == 1'b1) m_pending = 1;
            if (ball_done == 1'b1) m_phase = PH_IDLE;
        end else if (t) begin
            m_frames_left = m_frames_left - 1;
            if (m_frames_left == 0) m_phase = PH_IDLE;
        end
    endtask

    task automatic check_vec(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b (tick,pgo,bgo,brst,busy,serving,ovr)", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs == exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_bound(input string tag, input int n);
        vectors++;
        assert (n < 60) else begin
            miscompares++;
            $error("FAIL %s: observed %0d cycles expected below 60", tag, n);
        end
    endtask

    // one clock: responder drives dones, outputs checked at negedge, model advances
    task automatic cycle(input string tag);
        if (m_pgo) p_cnt = rand_delays ? int'($urandom_range(0, 6)) : p_delay;
        if (m_bgo) b_cnt = rand_delays ? int'($urandom_range(0, 6)) : b_delay;
        paddle_done = (p_cnt == 0) || spur_p;
        ball_done   = (b_cnt == 0) || spur_b;
        if (p_cnt >= 0) p_cnt--;
        if (b_cnt >= 0) b_cnt--;
        @(negedge clk);
        check_vec(tag, obs_vec(), exp_vec());
        if (frame_tick === 1'b1) tick_seen++;
        if (paddle_go === 1'b1) pgo_seen++;
        if (ball_go === 1'b1) bgo_seen++;
        model_step();
        @(posedge clk);
        #1;
        serve_req = 1'b0; clr_overrun = 1'b0; spur_p = 1'b0; spur_b = 1'b0;
        paddle_done = 1'b0; ball_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        model_reset();
        @(posedge clk);
        #1;
        check_vec("reset_state", obs_vec(), 7'b0);
        run = 1'b1;
        rst_n = 1'b1;

        // 1: steady frames, dones answered as soon as each go is seen
        tick_seen = 0; pgo_seen = 0; bgo_seen = 0;
        repeat (24) cycle("t1_frames");
        check_int("t1_tick_count", tick_seen, 6);
        check_int("t1_paddle_go_count", pgo_seen, 5);
        check_int("t1_ball_go_count", bgo_seen, 5);
        check_bit("t1_no_overrun", overrun, 1'b0);

        // 2: stalled paddle update
        p_delay = 10;
        pgo_seen = 0;
        repeat (12) cycle("t2_stall");
        check_int("t2_single_paddle_go", pgo_seen, 1);
        check_bit("t2_overrun_set", overrun, 1'b1);
        p_delay = 0;
        clr_overrun = 1'b1;
        cycle("t2_clear");
        check_bit("t2_overrun_cleared", overrun, 1'b0);
        p_delay = 10;
        n = 0;
        while (!(m_tick_now() && m_busy()) && n < 60) begin cycle("t2_seek"); n++; end
        check_bound("t2_seek_busy_tick", n);
        clr_overrun = 1'b1;
        cycle("t2_set_wins");
        check_bit("t2_set_beats_clear", overrun, 1'b1);
        p_delay = 0;
        n = 0;
        while (m_phase != PH_IDLE && n < 60) begin cycle("t2_drain"); n++; end
        check_bound("t2_drain", n);

        // 3: serve request during the ball update
        b_delay = 3;
        n = 0;
        while (m_phase != PH_BALL && n < 60) begin cycle("t3_seek"); n++; end
        check_bound("t3_seek_ball", n);
        serve_req = 1'b1;
        cycle("t3_req");
        n = 0;
        while (m_phase != PH_SERVE && n < 60) begin cycle("t3_wait"); n++; end
        check_bound("t3_wait_serve", n);
        check_bit("t3_ball_reset", ball_reset, 1'b1);
        check_bit("t3_serving", serving, 1'b1);
        b_delay = 0;
        pgo_seen = 0; tick_seen = 0;
        n = 0;
        while (m_phase == PH_SERVE && n < 60) begin cycle("t3_serve"); n++; end
        check_bound("t3_serve_len", n);
        check_int("t3_frozen_ticks", tick_seen, 2);
        check_int("t3_no_go_in_serve", pgo_seen, 0);
        n = 0;
        while (!m_tick_now() && n < 60) begin cycle("t3_to_tick3"); n++; end
        check_bound("t3_tick3", n);
        cycle("t3_tick3");
        check_bit("t3_paddle_go_after_tick3", paddle_go, 1'b1);

        // 4: pause with the divider at 2
        n = 0;
        while (m_div != 2 && n < 60) begin cycle("t4_seek"); n++; end
        check_bound("t4_seek_div2", n);
        run = 1'b0;
        tick_seen = 0;
        repeat (8) cycle("t4_paused");
        check_int("t4_no_tick_paused", tick_seen, 0);
        run = 1'b1;
        cycle("t4_resume");
        check_bit("t4_tick_after_resume", frame_tick, 1'b1);

        // 5: asynchronous reset while the paddle update is running
        p_delay = 5;
        n = 0;
        while (m_phase != PH_PADDLE && n < 60) begin cycle("t5_seek"); n++; end
        check_bound("t5_seek_paddle", n);
        #2;
        rst_n = 1'b0;
        #1;
        check_vec("t5_async_reset", obs_vec(), 7'b0);
        model_reset();
        p_delay = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick_seen = 0;
        repeat (3) cycle("t5_after_reset");
        check_int("t5_no_early_tick", tick_seen, 0);
        check_bit("t5_first_tick", frame_tick, 1'b1);

        // 6: serve request coinciding with a tick in IDLE
        n = 0;
        while (!(m_tick_now() && m_phase == PH_IDLE) && n < 60) begin cycle("t6_seek"); n++; end
        check_bound("t6_seek_idle_tick", n);
        serve_req = 1'b1;
        cycle("t6_collide");
        check_bit("t6_serving", serving, 1'b1);
        check_bit("t6_ball_reset", ball_reset, 1'b1);
        check_bit("t6_no_paddle_go", paddle_go, 1'b0);
        cycle("t6_after");

        // random traffic
        rand_delays = 1;
        for (int i = 0; i < 400; i++) begin
            run         = ($urandom_range(0, 9) != 0);
            serve_req   = ($urandom_range(0, 29) == 0);
            clr_overrun = ($urandom_range(0, 19) == 0);
            spur_p      = ($urandom_range(0, 29) == 0);
            spur_b      = ($urandom_range(0, 29) == 0);
            cycle("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
